lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage between the core's EX/MEM pipeline and the data-memory bus interface.
- Turns a single core access into a req/gnt/rvalid bus transaction and generates byte enables, lane-replicated write data and a word-aligned address.
- Formats returned load data with sign or zero extension and stalls the pipeline until the access completes.
- Handles exactly one outstanding access; never pipelines.

Parameters:
- ADDR_W, 32, address width for i_addr and data_addr_o.
- DATA_W, 32, data width; fixed at 32, used only for readability.

Ports:
- i_clk  input  1  core clock; all state updates on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_exe_wmem  input  1  store request from the pipeline.
- i_exe_mem2reg  input  1  load request from the pipeline.
- i_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  input  32  byte address of the access.
- i_wdata  input  32  store data; value in the low bits.
- o_stall  output  1  holds the pipeline while an access is in flight.
- o_valid  output  1  one-cycle completion pulse.
- o_rdata  output  32  formatted load data; valid with o_valid.
- o_bus_err  output  1  data_err_i captured with rvalid; valid with o_valid.
- o_misaligned  output  1  misalignment trap pulse (optional feature only).
- data_req_o  output  1  bus request.
- data_we_o  output  1  bus write enable.
- data_be_o  output  4  bus byte enables.
- data_addr_o  output  32  word-aligned bus address {addr[31:2],2'b00}.
- data_wdata_o  output  32  lane-replicated write data.
- data_gnt_i  input  1  bus grant.
- data_rvalid_i  input  1  bus response valid, for loads and stores.
- data_rdata_i  input  32  bus read data.
- data_err_i  input  1  bus error, qualified by rvalid.

Behaviour:
- Reset: state=IDLE. data_req_o, data_we_o, o_valid, o_bus_err, o_misaligned = 0. data_be_o=4'b0000. data_addr_o, data_wdata_o, o_rdata = 0.
- Access present = i_exe_wmem | i_exe_mem2reg. If both are set, the access is a store.
- IDLE:
  - o_stall = access present (combinational).
  - On an access: latch we, funct3, addr, and formatted be/wdata into registers; go to REQ.
  - data_rvalid_i and data_gnt_i are ignored in IDLE.
- REQ:
  - data_req_o=1; we/be/addr/wdata driven from the latch and held stable until grant.
  - On data_gnt_i go to WAIT; data_req_o drops the next cycle. o_stall=1.
- WAIT:
  - data_req_o=0, o_stall=1.
  - On data_rvalid_i: register the formatted load data into o_rdata and data_err_i into o_bus_err; go to DONE.
  - rvalid in the same cycle as gnt is not possible on this bus and is not expected.
- DONE: o_valid=1, o_stall=0, so the pipeline advances this cycle; always returns to IDLE. A new access is sampled only in IDLE.
- Minimum latency, with gnt in the first REQ cycle and rvalid one cycle later:
  - access seen at cycle 0 (IDLE);
  - req at cycle 1;
  - rvalid at cycle 2;
  - o_valid at cycle 3;
  - o_stall high for cycles 0–2.
- Store formatting:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
- Load formatting:
  - Byte lane is addr[1:0]; half lane is addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes data through.
  - Loads drive be as for the store of the same size.
- Undefined funct3 (011, 110, 111): treated as a word access.
- o_rdata holds its last value outside DONE; it is 0 after a store completes.
- Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0. Handling is set by the optional feature below.
- Reset mid-operation: i_rst in any state returns to IDLE on that edge and data_req_o=0 the next cycle. Any late rvalid after reset is ignored and produces no o_valid.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access in IDLE issues no bus request and stays in IDLE.
  - o_misaligned pulses high for one cycle, registered, in the cycle after detection.
  - o_stall=0 in the detection cycle.
- Undefined:
  - o_misaligned is tied to 0.
  - Misaligned low address bits are ignored: H uses lane addr[1], W uses lane 0, and the access proceeds normally.

Test Plan:
- LW, addr=0x100, gnt in the first REQ cycle, rvalid one cycle later with rdata=0xDEADBEEF -> data_addr_o=0x100, be=1111; o_valid at cycle 3 with o_rdata=0xDEADBEEF; o_stall high for cycles 0–2.
- SB, addr=0x203, wdata=0x000000A5 -> data_we_o=1, be=1000, data_wdata_o=0xA5A5A5A5, data_addr_o=0x200; o_valid after rvalid; o_rdata=0.
- LB at addr=0x2 and LBU at addr=0x2, both with rdata=0x0080FF00 -> o_rdata=0xFFFFFF80 for LB and 0x00000080 for LBU. LH at addr=0x2 with rdata=0x80000000 -> o_rdata=0xFFFF8000.
- Grant delayed 3 cycles -> req, addr, be and wdata stay stable for all 4 REQ cycles; o_stall stays high; o_valid is exactly one pulse.
- i_rst asserted during WAIT, then rvalid arrives -> IDLE, no o_valid, data_req_o=0; a following LW completes normally.
- With LSU_MISALIGN_TRAP_EN defined, LW at addr=0x102 -> no data_req_o and an o_misaligned one-cycle pulse. Without the macro -> access to word 0x100 with be=1111.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage between EX/MEM and the data bus.
// Runs one access at a time as a req/gnt/rvalid transaction.
//
// Pipeline side:
//   i_exe_wmem / i_exe_mem2reg : store / load request (both set = store)
//   i_funct3, i_addr, i_wdata  : size/sign, byte address, store data
//   o_stall  : hold pipeline while the access is in flight
//   o_valid  : one-cycle completion pulse; qualifies o_rdata, o_bus_err
//   o_misaligned : misalignment trap pulse (trap build only)
// Bus side:
//   data_req_o/we_o/be_o/addr_o/wdata_o : request, held until data_gnt_i
//   data_rvalid_i/rdata_i/err_i         : response for loads and stores
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W
// accesses instead of silently ignoring the low address bits.

module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_exe_wmem,
  input  logic              i_exe_mem2reg,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_stall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_bus_err,
  output logic              o_misaligned,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  input  logic              data_err_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic access;
  logic is_b;
  logic is_h;
  logic mis;
  logic go;

  assign access = i_exe_wmem | i_exe_mem2reg;
  assign is_b   = (i_funct3[1:0] == 2'b00);
  assign is_h   = (i_funct3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  // Undefined funct3 decodes as word, so anything not B/H is W.
  assign mis = (is_h & i_addr[0])
             | (~is_b & ~is_h & (|i_addr[1:0]));
`else
  assign mis = 1'b0;
`endif

  assign go = access & ~mis;

  // Store formatting: lane-select the enables, replicate the data.
  logic [3:0]        be_fmt;
  logic [DATA_W-1:0] wd_fmt;

  always_comb begin
    be_fmt = 4'b1111;
    wd_fmt = i_wdata;
    unique case (1'b1)
      is_b: begin
        be_fmt = 4'b0001 << i_addr[1:0];
        wd_fmt = {4{i_wdata[7:0]}};
      end
      is_h: begin
        be_fmt = 4'b0011 << {i_addr[1], 1'b0};
        wd_fmt = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Latched access
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wd_q;

  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign data_wdata_o = wd_q;

  // Load formatting, from the latched lane and size.
  logic              q_b;
  logic              q_h;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_fmt;

  assign q_b = (f3_q[1:0] == 2'b00);
  assign q_h = (f3_q[1:0] == 2'b01);

  always_comb begin
    ld_byte = data_rdata_i[7:0];
    unique case (addr_q[1:0])
      2'b00: ld_byte = data_rdata_i[7:0];
      2'b01: ld_byte = data_rdata_i[15:8];
      2'b10: ld_byte = data_rdata_i[23:16];
      2'b11: ld_byte = data_rdata_i[31:24];
    endcase
  end

  assign ld_half = addr_q[1] ? data_rdata_i[31:16]
                             : data_rdata_i[15:0];

  // funct3[2] marks the unsigned variants.
  always_comb begin
    ld_fmt = data_rdata_i;
    unique case (1'b1)
      q_b: ld_fmt = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      q_h: ld_fmt = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx   = state;
    o_stall    = 1'b0;
    o_valid    = 1'b0;
    data_req_o = 1'b0;
    unique case (state)
      S_IDLE: begin
        o_stall = go;
        if (go) state_nx = S_REQ;
      end
      S_REQ: begin
        o_stall    = 1'b1;
        data_req_o = 1'b1;
        if (data_gnt_i) state_nx = S_WAIT;
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (data_rvalid_i) state_nx = S_DONE;
      end
      S_DONE: begin
        o_valid  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wd_q      <= '0;
      o_rdata   <= '0;
      o_bus_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && go) begin
        we_q   <= i_exe_wmem;
        f3_q   <= i_funct3;
        addr_q <= i_addr;
        be_q   <= be_fmt;
        wd_q   <= wd_fmt;
      end
      if (state == S_WAIT && data_rvalid_i) begin
        o_rdata   <= we_q ? '0 : ld_fmt;
        o_bus_err <= data_err_i;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) mis_q <= 1'b0;
    else       mis_q <= (state == S_IDLE) & access & mis;
  end

  assign o_misaligned = mis_q;
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plus randomized bench for lsu_ctrl.
// Expected bus/load values come from an arithmetic reference model.

module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wmem;
  logic        m2r;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        valid;
  logic [31:0] rdata;
  logic        bus_err;
  logic        misal;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] baddr;
  logic [31:0] bwdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] brdata;
  logic        berr;

  int ncmp = 0;
  int nmis = 0;

  lsu_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_exe_wmem    (wmem),
    .i_exe_mem2reg (m2r),
    .i_funct3      (f3),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_stall       (stall),
    .o_valid       (valid),
    .o_rdata       (rdata),
    .o_bus_err     (bus_err),
    .o_misaligned  (misal),
    .data_req_o    (req),
    .data_we_o     (we),
    .data_be_o     (be),
    .data_addr_o   (baddr),
    .data_wdata_o  (bwdata),
    .data_gnt_i    (gnt),
    .data_rvalid_i (rvalid),
    .data_rdata_i  (brdata),
    .data_err_i    (berr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes and the lane it lives in.
  function automatic int sz_of(input logic [2:0] fn);
    case (fn)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int lane_of(input logic [2:0] fn,
                                 input logic [31:0] a);
    int s;
    s = sz_of(fn);
    return (int'(a % 4) / s) * s;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] fn,
                                      input logic [31:0] a);
    int v;
    v = ((1 << sz_of(fn)) - 1) << lane_of(fn, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] fn,
                                       input logic [31:0] d);
    case (sz_of(fn))
      1:       return {24'd0, d[7:0]} * 32'h01010101;
      2:       return {16'd0, d[15:0]} * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] fn,
                                       input logic [31:0] a,
                                       input logic [31:0] d);
    longint v;
    longint span;
    int s;
    s    = sz_of(fn);
    span = longint'(1) << (8 * s);
    v    = longint'(d >> (8 * lane_of(fn, a))) % span;
    if ((fn == 3'b000 || fn == 3'b001) && v >= span / 2)
      v = v - span;
    return v[31:0];
  endfunction

  function automatic bit m_mis(input logic [2:0] fn,
                               input logic [31:0] a);
    return (a % sz_of(fn)) != 0;
  endfunction

  // One full access. Entered and left at a falling edge, in IDLE.
  task automatic xact(input string tag, input logic st,
                      input logic [2:0] fn, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input logic er, input int gd, input int rvd);
    logic [31:0] e_rd;
    e_rd  = st ? 32'd0 : m_rd(fn, a, rd);
    wmem  = st;
    m2r   = ~st | 1'($urandom_range(0, 1));
    f3    = fn;
    addr  = a;
    wdata = wd;
    #1;
    chk({tag, ".stall0"}, 32'(stall), 32'd1);
    chk({tag, ".req0"}, 32'(req), 32'd0);
    @(negedge clk);
    for (int i = 0; i <= gd; i++) begin
      chk({tag, ".req"}, 32'(req), 32'd1);
      chk({tag, ".we"}, 32'(we), 32'(st));
      chk({tag, ".be"}, 32'(be), 32'(m_be(fn, a)));
      chk({tag, ".addr"}, baddr, {a[31:2], 2'b00});
      chk({tag, ".wdata"}, bwdata, m_wd(fn, wd));
      chk({tag, ".stall_req"}, 32'(stall), 32'd1);
      if (i == gd) gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
    end
    for (int j = 0; j <= rvd; j++) begin
      chk({tag, ".req_wait"}, 32'(req), 32'd0);
      chk({tag, ".stall_wait"}, 32'(stall), 32'd1);
      chk({tag, ".valid_wait"}, 32'(valid), 32'd0);
      if (j == rvd) begin
        rvalid = 1'b1;
        brdata = rd;
        berr   = er;
      end
      @(negedge clk);
      rvalid = 1'b0;
      berr   = 1'b0;
      brdata = $urandom;
    end
    chk({tag, ".valid"}, 32'(valid), 32'd1);
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".rdata"}, rdata, e_rd);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(er));
    wmem = 1'b0;
    m2r  = 1'b0;
    @(negedge clk);
    chk({tag, ".valid_pulse"}, 32'(valid), 32'd0);
    chk({tag, ".rdata_hold"}, rdata, e_rd);
    chk({tag, ".req_idle"}, 32'(req), 32'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    rst    = 1'b1;
    wmem   = 1'b0;
    m2r    = 1'b0;
    f3     = 3'b000;
    addr   = 32'd0;
    wdata  = 32'd0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    brdata = 32'd0;
    berr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.req", 32'(req), 32'd0);
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.be", 32'(be), 32'd0);
    chk("rst.addr", baddr, 32'd0);
    chk("rst.wdata", bwdata, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    chk("rst.misal", 32'(misal), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    @(negedge clk);

    xact("lw", 1'b0, 3'b010, 32'h100, 32'h0,
         32'hDEADBEEF, 1'b0, 0, 0);
    chk("lw.rdata_k", rdata, 32'hDEADBEEF);
    chk("lw.addr_k", baddr, 32'h100);

    xact("sb", 1'b1, 3'b000, 32'h203, 32'h000000A5,
         32'h12345678, 1'b0, 0, 0);
    chk("sb.be_k", 32'(be), 32'h8);
    chk("sb.wdata_k", bwdata, 32'hA5A5A5A5);
    chk("sb.addr_k", baddr, 32'h200);
    chk("sb.rdata_k", rdata, 32'd0);

    xact("lb", 1'b0, 3'b000, 32'h2, 32'h0,
         32'h0080FF00, 1'b0, 0, 0);
    chk("lb.rdata_k", rdata, 32'hFFFFFF80);
    xact("lbu", 1'b0, 3'b100, 32'h2, 32'h0,
         32'h0080FF00, 1'b0, 0, 0);
    chk("lbu.rdata_k", rdata, 32'h00000080);
    xact("lh", 1'b0, 3'b001, 32'h2, 32'h0,
         32'h80000000, 1'b0, 0, 0);
    chk("lh.rdata_k", rdata, 32'hFFFF8000);

    xact("gnt3", 1'b1, 3'b001, 32'h412, 32'hCAFE1234,
         32'h0, 1'b1, 3, 1);

    // Reset while waiting for rvalid; the late response is dropped.
    wmem = 1'b0;
    m2r  = 1'b1;
    f3   = 3'b010;
    addr = 32'h300;
    @(negedge clk);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("mrst.stall_wait", 32'(stall), 32'd1);
    rst  = 1'b1;
    m2r  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.req", 32'(req), 32'd0);
    chk("mrst.valid", 32'(valid), 32'd0);
    chk("mrst.stall", 32'(stall), 32'd0);
    rvalid = 1'b1;
    brdata = 32'h55AA55AA;
    @(negedge clk);
    rvalid = 1'b0;
    chk("mrst.late_valid", 32'(valid), 32'd0);
    chk("mrst.late_req", 32'(req), 32'd0);
    @(negedge clk);
    chk("mrst.late_valid2", 32'(valid), 32'd0);
    xact("mrst.lw", 1'b0, 3'b010, 32'h304, 32'h0,
         32'h01020304, 1'b0, 0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    m2r  = 1'b1;
    f3   = 3'b010;
    addr = 32'h102;
    #1;
    chk("mis.stall", 32'(stall), 32'd0);
    chk("mis.req0", 32'(req), 32'd0);
    @(negedge clk);
    m2r = 1'b0;
    chk("mis.pulse", 32'(misal), 32'd1);
    chk("mis.req1", 32'(req), 32'd0);
    @(negedge clk);
    chk("mis.pulse_end", 32'(misal), 32'd0);
    chk("mis.req2", 32'(req), 32'd0);
`else
    xact("mis", 1'b0, 3'b010, 32'h102, 32'h0,
         32'h89ABCDEF, 1'b0, 0, 0);
    chk("mis.addr_k", baddr, 32'h100);
    chk("mis.be_k", 32'(be), 32'hF);
    chk("mis.flag", 32'(misal), 32'd0);
`endif

    for (int k = 0; k < 40; k++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      if (m_mis(rf, ra)) ra = ra - (ra % sz_of(rf));
`endif
      xact($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
           rf, ra, $urandom, $urandom,
           1'($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nmis);
    $finish;
  end

endmodule
